// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with zero-latency pop read and sticky overflow/underflow flags
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              pc,
  output logic [AW-1:0]              retTarget,
  output logic                       retValid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push, pop, wr;
  logic [AW-1:0] push_val;
  assign count     = count_q;
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign retTarget = empty ? '0 : mem_q[top_q];
  assign retValid  = ret & ~empty & ~stall & ~flush & ~reset;
  assign push_val  = pc + AW'(2);
  // call+ret on an empty stack degrades to a plain push; otherwise it rewrites the top in place
  always_comb begin
    push    = call & (~ret | empty);
    pop     = ret & ~call & ~empty;
    wr      = call;
    top_d   = push ? top_q + PW'(1) : pop ? top_q - PW'(1) : top_q;
    count_d = push ? (full ? count_q : count_q + CW'(1)) : pop ? count_q - CW'(1) : count_q;
    ovf_d   = ovf_q | (push & full);
    unf_d   = unf_q | (ret & empty);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (!stall) begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (wr) mem_q[top_d] <= push_val;
    end
  end
endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of stack entries; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter AW, default 16, giving the address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port stall, input, 1 bit: when high, the block holds all state.
REQ-006 Port flush, input, 1 bit: pipeline flush; empties the stack.
REQ-007 Port call, input, 1 bit: a call instruction is in the decode stage; push the return address.
REQ-008 Port ret, input, 1 bit: a return instruction is in the decode stage; pop.
REQ-009 Port pc, input, AW bits: PC of the instruction that asserts call or ret.
REQ-010 Port retTarget, output, AW bits: the return address presented to the PC mux.
REQ-011 Port retValid, output, 1 bit: retTarget is valid for the current ret.
REQ-012 Port count, output, log2(DEPTH)+1 bits: current number of valid entries.
REQ-013 Ports full and empty, outputs, 1 bit each: count==DEPTH and count==0 respectively.
REQ-014 Ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x AW registers with a top pointer of log2(DEPTH) bits; the pointer SHALL wrap modulo DEPTH.
REQ-016 retTarget SHALL be combinational from the top entry when count>0; when count==0 it SHALL be all zeros.
REQ-017 retValid SHALL equal ret & ~empty & ~stall & ~flush & ~reset.
REQ-018 Push value SHALL be pc+2, truncated to AW bits; 16'hFFFE SHALL push 16'h0000.
REQ-019 Push only (call=1, ret=0): at the next edge the pointer SHALL advance, pc+2 SHALL be written at the new top, and count SHALL increment.
REQ-020 Push when full: the oldest entry SHALL be overwritten (circular), count SHALL stay at DEPTH, and overflow SHALL be set.
REQ-021 Pop only (call=0, ret=1, count>0): the pointer SHALL retreat and count SHALL decrement at the next edge; retTarget SHALL show the popped value during the ret cycle (zero-cycle read latency).
REQ-022 Pop when empty: there SHALL be no pointer or count change, retValid SHALL be 0, retTarget SHALL be 0, and underflow SHALL be set.
REQ-023 Simultaneous call and ret with count>0: retTarget SHALL present the old top; at the edge the top entry SHALL be replaced with pc+2; pointer and count SHALL be unchanged.
REQ-024 Simultaneous call and ret with count==0: this SHALL be treated as a push; underflow SHALL be set; retValid SHALL be 0.
REQ-025 stall=1 SHALL block every state change, including the flags; outputs SHALL reflect the held state.
REQ-026 flush=1 SHALL take priority over call, ret and stall: at the next edge count SHALL be 0 and the pointer 0; entry contents are don't-care; the sticky flags SHALL be kept.
REQ-027 Priority at each edge SHALL be reset > flush > stall > call/ret.
REQ-028 full and empty SHALL be combinational from count.
REQ-029 overflow and underflow SHALL clear only on reset.

Reset
REQ-030 While reset is high at an edge: the pointer SHALL become 0, count 0, overflow 0, underflow 0; storage SHALL be cleared to zero.
REQ-031 After that edge: empty=1, full=0, retTarget=0, retValid=0.
REQ-032 Reset asserted during a call or ret SHALL discard the operation; the push or pop SHALL have no effect.

Verification
REQ-033 Reset, then call with pc=16'h0100, then call with pc=16'h0200, then ret, then ret -> retTarget 16'h0202 then 16'h0102, retValid=1 for both; afterwards count=0 and empty=1.
REQ-034 DEPTH=8: 9 calls with pc=16'h0010*i for i=1..9 -> count=8, full=1, overflow=1; 8 rets return 16'h0092 down to 16'h0022; the 9th ret gives retValid=0, retTarget=0, underflow=1.
REQ-035 With entries {16'h0102, 16'h0202}: call=ret=1 with pc=16'h0300 -> retTarget=16'h0202 that cycle; next cycle the top is 16'h0302 and count=2.
REQ-036 call with stall=1 -> no change in count; then call with flush=1 and stall=1 -> count=0; sticky flags unchanged.
REQ-037 call with pc=16'hFFFE -> pushed value 16'h0000; a ret in the next cycle -> retTarget=16'h0000 with retValid=1.
REQ-038 reset asserted in the same cycle as call, with 3 entries present -> next cycle count=0, overflow=0, underflow=0.
